// File: rtl/rsa_operand_loader.sv
`timescale 1ns/1ps
// rsa_operand_loader
//   Loads NUM_OPS operands word by word from a valid/ready stream into OP_W-bit
//   registers. It then pulses start to the modular-arithmetic core and waits for
//   core_done. The captured result is streamed back out word by word.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand beat handshake
//   in_word               operand k's word in bits [k*WORD_W +: WORD_W]
//   op_data               assembled operands, operand k in [k*OP_W +: OP_W]
//   start                 one-cycle core start pulse
//   core_done/core_result core completion pulse and result
//   out_valid/out_ready   result word handshake
//   out_word              current result word
//   busy                  high whenever the loader is not in its load phase
module rsa_operand_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned OP_W      = 512,
  parameter int unsigned NUM_OPS   = 2,
  parameter bit          MSW_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*WORD_W-1:0] in_word,
  output logic [NUM_OPS*OP_W-1:0]   op_data,
  output logic                      start,
  input  logic                      core_done,
  input  logic [OP_W-1:0]           core_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_word,
  output logic                      busy
);

  localparam int unsigned BEATS = OP_W / WORD_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      load_fire, unload_fire, capture;
  logic                      in_ready_d, start_d, out_valid_d, busy_d;
  logic [NUM_OPS*OP_W-1:0]   op_next;
  logic [OP_W-1:0]           result_q, result_shift;

  // Word-order specific shift paths; out_word is always the word nearest the exit end.
  if (MSW_FIRST) begin : g_msw
    always_comb begin
      op_next = op_data;
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        op_next[k*OP_W +: OP_W] = {op_data[k*OP_W +: (OP_W-WORD_W)],
                                   in_word[k*WORD_W +: WORD_W]};
      end
    end
    assign result_shift = {result_q[OP_W-WORD_W-1:0], {WORD_W{1'b0}}};
    assign out_word     = result_q[OP_W-1 -: WORD_W];
  end else begin : g_lsw
    always_comb begin
      op_next = op_data;
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        op_next[k*OP_W +: OP_W] = {in_word[k*WORD_W +: WORD_W],
                                   op_data[k*OP_W+WORD_W +: (OP_W-WORD_W)]};
      end
    end
    assign result_shift = {{WORD_W{1'b0}}, result_q[OP_W-1:WORD_W]};
    assign out_word     = result_q[WORD_W-1:0];
  end

  // Next-state, counter and handshake decode; flag outputs are precomputed from state_d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_fire   = 1'b0;
    unload_fire = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready) begin
          load_fire = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (out_valid && out_ready) begin
          unload_fire = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == S_LOAD);
    start_d     = (state_d == S_START);
    out_valid_d = (state_d == S_UNLOAD);
    busy_d      = (state_d != S_LOAD);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      start     <= start_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_data  <= '0;
      result_q <= '0;
    end else begin
      if (load_fire) begin
        op_data <= op_next;
      end
      if (capture) begin
        result_q <= core_result;
      end else if (unload_fire) begin
        result_q <= result_shift;
      end
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
`timescale 1ns/1ps
// Directed bench for rsa_operand_loader: default LSW-first instance plus a
// 64/256-bit MSW-first single-operand instance sharing clock and reset.
module tb_rsa_operand_loader;

  localparam int unsigned WW = 32;
  localparam int unsigned OW = 512;
  localparam int unsigned NO = 2;
  localparam int unsigned BT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic              in_valid, in_ready, start, core_done, out_valid, out_ready, busy;
  logic [NO*WW-1:0]  in_word;
  logic [NO*OW-1:0]  op_data;
  logic [OW-1:0]     core_result;
  logic [WW-1:0]     out_word;

  // MSW-first instance
  logic              m_in_valid, m_in_ready, m_start, m_core_done, m_out_valid, m_out_ready, m_busy;
  logic [63:0]       m_in_word, m_out_word;
  logic [255:0]      m_op_data, m_core_result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] res_inc, res_ones, res_b;

  rsa_operand_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .op_data(op_data), .start(start),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .busy(busy)
  );

  rsa_operand_loader #(.WORD_W(64), .OP_W(256), .NUM_OPS(1), .MSW_FIRST(1'b1)) dut_msw (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_word(m_in_word),
    .op_data(m_op_data), .start(m_start),
    .core_done(m_core_done), .core_result(m_core_result),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_word(m_out_word),
    .busy(m_busy)
  );

  // Expected operands: q word i = qb+i, p word i = pb+i.
  function automatic logic [NO*OW-1:0] exp_ops(input int qb, input int pb);
    logic [NO*OW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(BT); i++) begin
      v[i*WW +: WW]      = 32'(qb + i);
      v[OW + i*WW +: WW] = 32'(pb + i);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds 16 beats; a set bit in gaps drops in_valid for that cycle. Ends in the START cycle.
  task automatic do_load(input int qb, input int pb, input logic [31:0] gaps, output int cycles);
    int acc;
    acc    = 0;
    cycles = 0;
    while (acc < int'(BT) && cycles < 100) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_in_ready: got %0b expected 1 (beat %0d)", in_ready, acc);
      end
      in_valid = !gaps[cycles % 32];
      in_word  = {32'(pb + acc), 32'(qb + acc)};
      tick();
      if (in_valid) acc++;
      cycles++;
      if (acc < int'(BT)) begin
        n_checks++;
        if (start !== 1'b0) begin
          n_fail++;
          $display("FAIL load_early_start: got %0b expected 0 after %0d beats", start, acc);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc != int'(BT)) begin
      n_fail++;
      $display("FAIL load_timeout: got %0d beats expected %0d", acc, BT);
    end
    n_checks++;
    if (start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start_flags: got start=%0b busy=%0b in_ready=%0b expected 1 1 0",
               start, busy, in_ready);
    end
    n_checks++;
    if (op_data !== exp_ops(qb, pb)) begin
      n_fail++;
      $display("FAIL load_op_data: got %0h expected %0h", op_data, exp_ops(qb, pb));
    end
  endtask

  // START -> WAIT; start must be a single-cycle pulse.
  task automatic finish_start();
    tick();
    n_checks++;
    if (start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: got start=%0b out_valid=%0b busy=%0b expected 0 0 1",
               start, out_valid, busy);
    end
  endtask

  // One-cycle core_done in WAIT; first result word must appear next cycle.
  task automatic do_done(input logic [OW-1:0] res);
    core_result = res;
    core_done   = 1'b1;
    tick();
    core_done   = 1'b0;
    core_result = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== res[WW-1:0]) begin
      n_fail++;
      $display("FAIL done_first_word: got valid=%0b word=%0h expected 1 %0h",
               out_valid, out_word, res[WW-1:0]);
    end
  endtask

  // Drain 16 words; toggle=1 drives out_ready 1,0,1,0... A stalled word is rechecked next cycle.
  task automatic do_unload(input logic [OW-1:0] res, input bit toggle);
    int   i;
    int   cyc;
    logic ph;
    i   = 0;
    cyc = 0;
    ph  = 1'b1;
    while (i < int'(BT) && cyc < 100) begin
      out_ready = toggle ? ph : 1'b1;
      ph        = ~ph;
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== res[i*WW +: WW]) begin
        n_fail++;
        $display("FAIL unload_word%0d: got valid=%0b word=%0h expected 1 %0h",
                 i, out_valid, out_word, res[i*WW +: WW]);
      end
      tick();
      if (out_ready) i++;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (i != int'(BT)) begin
      n_fail++;
      $display("FAIL unload_timeout: got %0d words expected %0d", i, BT);
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unload_end_flags: got out_valid=%0b in_ready=%0b busy=%0b expected 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got in_ready=%0b start=%0b out_valid=%0b busy=%0b expected 1 0 0 0",
               in_ready, start, out_valid, busy);
    end
    n_checks++;
    if (op_data !== '0 || out_word !== '0 || m_op_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got op_data=%0h out_word=%0h expected 0", op_data, out_word);
    end
  endtask

  task automatic test_continuous();
    int cyc;
    do_load(1, 32'h100, 32'h0, cyc);
    n_checks++;
    if (cyc != int'(BT)) begin
      n_fail++;
      $display("FAIL continuous_cycles: got %0d expected %0d", cyc, BT);
    end
    finish_start();
    do_done(res_inc);
    do_unload(res_inc, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    do_load(1, 32'h100, 32'b0110_1001_0011_0101_1000_1100_1010_0110, cyc);
    finish_start();
    do_done(res_inc);
    do_unload(res_inc, 1'b1);
  endtask

  task automatic test_spurious_done();
    int cyc;
    core_done   = 1'b1;
    core_result = res_inc;
    do_load(5, 32'h500, 32'h0, cyc);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || start !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_start_done: got out_valid=%0b start=%0b expected 0 0", out_valid, start);
    end
    core_done = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_wait_hold: got out_valid=%0b busy=%0b expected 0 1", out_valid, busy);
    end
    do_done(res_ones);
    do_unload(res_ones, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    // reset after 7 beats, with a beat still presented during reset
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_word = {32'(32'h900 + i), 32'(32'h800 + i)};
      tick();
    end
    in_word = 64'hDEAD_BEEF_CAFE_F00D;
    rst_n   = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    n_checks++;
    if (op_data !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_load: got op_data=%0h in_ready=%0b busy=%0b expected 0 1 0",
               op_data, in_ready, busy);
    end
    do_load(1, 32'h100, 32'h0, cyc);
    // reset during WAIT; the later done must not start an unload
    finish_start();
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    core_done   = 1'b1;
    core_result = res_ones;
    tick();
    core_done = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got out_valid=%0b in_ready=%0b busy=%0b expected 0 1 0",
               out_valid, in_ready, busy);
    end
    // reset during UNLOAD after three words
    do_load(1, 32'h100, 32'h0, cyc);
    finish_start();
    do_done(res_inc);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_word !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_unload_word3: got %0h expected 3", out_word);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_unload: got out_valid=%0b out_word=%0h in_ready=%0b expected 0 0 1",
               out_valid, out_word, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_load(32'h1000, 32'h2000, 32'h0, cyc);
    finish_start();
    do_done(res_inc);
    do_unload(res_inc, 1'b0);
    n_checks++;
    if (op_data !== exp_ops(32'h1000, 32'h2000)) begin
      n_fail++;
      $display("FAIL b2b_op_data_held: got %0h expected %0h", op_data, exp_ops(32'h1000, 32'h2000));
    end
    do_load(32'h3000, 32'h4000, 32'h0, cyc);
    n_checks++;
    if (cyc != int'(BT)) begin
      n_fail++;
      $display("FAIL b2b_cycles: got %0d expected %0d", cyc, BT);
    end
    finish_start();
    do_done(res_b);
    do_unload(res_b, 1'b0);
  endtask

  task automatic test_msw_first();
    logic [63:0]  beats [4];
    logic [255:0] r;
    beats[0] = 64'hAAAA_0000_1111_2222;
    beats[1] = 64'hBBBB_3333_4444_5555;
    beats[2] = 64'hCCCC_6666_7777_8888;
    beats[3] = 64'hDDDD_9999_EEEE_FFFF;
    r = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    m_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_in_word = beats[i];
      tick();
    end
    m_in_valid = 1'b0;
    n_checks++;
    if (m_start !== 1'b1 || m_op_data !== {beats[0], beats[1], beats[2], beats[3]}) begin
      n_fail++;
      $display("FAIL msw_op_data: got start=%0b op=%0h expected 1 %0h",
               m_start, m_op_data, {beats[0], beats[1], beats[2], beats[3]});
    end
    tick();
    m_core_result = r;
    m_core_done   = 1'b1;
    tick();
    m_core_done = 1'b0;
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_out_valid !== 1'b1 || m_out_word !== r[255-64*i -: 64]) begin
        n_fail++;
        $display("FAIL msw_word%0d: got valid=%0b word=%0h expected 1 %0h",
                 i, m_out_valid, m_out_word, r[255-64*i -: 64]);
      end
      tick();
    end
    m_out_ready = 1'b0;
    n_checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL msw_end: got out_valid=%0b in_ready=%0b expected 0 1", m_out_valid, m_in_ready);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_word       = '0;
    core_done     = 1'b0;
    core_result   = '0;
    out_ready     = 1'b0;
    m_in_valid    = 1'b0;
    m_in_word     = '0;
    m_core_done   = 1'b0;
    m_core_result = '0;
    m_out_ready   = 1'b0;
    res_ones      = '1;
    for (int i = 0; i < int'(BT); i++) begin
      res_inc[i*WW +: WW] = 32'(i);
      res_b[i*WW +: WW]   = 32'(32'hA5A5_0000 + 7*i);
    end

    test_reset();
    test_continuous();
    test_backpressure();
    test_spurious_done();
    test_reset_mid();
    test_back_to_back();
    test_msw_first();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_operand_loader.md
# rsa_operand_loader

Parametrised operand loader and result unloader for the RSA decryption datapath. It deserialises NUM_OPS operands (e.g. q and p) from parallel WORD_W-bit streams into OP_W-bit registers under a valid/ready handshake, then issues a one-cycle start pulse to the modular-arithmetic core. It waits for the core's done pulse, captures the OP_W-bit result, and serialises it back out word by word. It replaces the fixed 16×32-bit free-running shift loader and adds flow control, reuse, word-order selection and a result path.

## Interface
- WORD_W, 32: stream word width.
- OP_W, 512: operand and result width. Must be a multiple of WORD_W, with OP_W/WORD_W ≥ 2.
- NUM_OPS, 2: operands loaded in parallel per beat.
- MSW_FIRST, 0: 0 = least-significant word first on both in and out streams; 1 = most-significant word first.
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  in_word holds a beat.
- in_ready  out  1  loader accepts a beat.
- in_word  in  NUM_OPS*WORD_W  operand k's word occupies bits [k*WORD_W +: WORD_W].
- op_data  out  NUM_OPS*OP_W  assembled operands; operand k occupies bits [k*OP_W +: OP_W].
- start  out  1  one-cycle core start pulse.
- core_done  in  1  one-cycle pulse from the core; result is valid in that cycle.
- core_result  in  OP_W  core output, e.g. m.
- out_valid  out  1  out_word holds a result word.
- out_ready  in  1  downstream accepts out_word.
- out_word  out  WORD_W  current result word.
- busy  out  1  high in every state except LOAD.

## Operation
- BEATS = OP_W/WORD_W. The beat counter is $clog2(BEATS) bits wide.
- States and transitions:
  - LOAD
    - in_ready = 1.
    - Each accepted beat (in_valid && in_ready) shifts word k into operand register k and increments the counter.
    - LSW-first: the new word enters at the top and the register shifts right by WORD_W, so the first word ends in bits [WORD_W-1:0].
    - MSW-first: the new word enters at the bottom and the register shifts left.
    - When the beat with counter == BEATS-1 is accepted: counter ← 0, go to START.
  - START
    - start = 1 for exactly one cycle.
    - core_done is ignored in this state.
    - Go to WAIT.
  - WAIT
    - Hold until core_done = 1.
    - On core_done, capture core_result into the result register, counter ← 0, go to UNLOAD.
  - UNLOAD
    - out_valid = 1.
    - out_word is the low word (LSW-first) or the high word (MSW-first) of the result register.
    - Each accepted word (out_valid && out_ready) shifts the result register by WORD_W and increments the counter.
    - When word BEATS-1 is accepted: counter ← 0, go to LOAD.
- op_data is stable from the final load beat until the first beat of the next load is accepted. The core may therefore sample it at any time during START, WAIT or UNLOAD.
- in_ready = 0 outside LOAD. Beats presented then are not consumed and must be held by the source.
- core_done outside WAIT is ignored, and no result is captured.
- Reset (rst_n = 0 at a rising edge) has priority over every other event.
  - Reset values: state = LOAD, counter = 0, op_data = 0, result register = 0, start = 0, out_valid = 0, out_word = 0, busy = 0.
  - in_ready reads 1 after the reset edge.
  - Reset mid-load discards the partial operands.
  - Reset during WAIT abandons the transaction; a later core_done is ignored.
  - Reset during UNLOAD drops the remaining words.
  - A beat presented in the same cycle as reset is not accepted.

## Timing
- All outputs are decoded from registered state and data, with no combinational path from inputs to outputs.
- Load throughput: 1 beat/cycle with in_valid held high. A full load takes BEATS cycles.
- start goes high the cycle after the final beat is accepted, and op_data already holds the complete operands in that cycle.
- Earliest core_done is sampled in the cycle after start.
- out_valid goes high the cycle after core_done is sampled, with the first word already on out_word.
- Unload throughput: 1 word/cycle with out_ready high.
- in_ready rises the cycle after the last result word is accepted.
- Minimum round trip with zero-latency done and no back-pressure: BEATS + 2 + BEATS cycles.
- out_word and out_valid stay constant while out_ready = 0.

## Test plan
- Defaults, continuous load: beat i carries q = i+1, p = 0x100+i for i = 0..15. Required: op_data[511:0] word i = i+1, op_data[1023:512] word i = 0x100+i, start pulses exactly once in cycle 17, busy = 1 from cycle 17.
- Back-pressure:
  - Random in_valid gaps during load: same op_data as the continuous case, start only after the 16th accepted beat.
  - out_ready toggled 1010… during unload of core_result = 512'h0F…0E…00 (word i = i): words out 0..15 in order, none dropped or repeated, out_word stable while stalled.
- Spurious done: core_done asserted during LOAD and START is ignored. In WAIT with core_result = all-ones, 16 words of 0xFFFFFFFF are emitted.
- Reset mid-operation:
  - rst_n low after 7 load beats: op_data = 0, counter = 0; a fresh 16-beat load then produces correct op_data.
  - rst_n low during UNLOAD: out_valid = 0 the next cycle.
- MSW_FIRST = 1, WORD_W = 64, OP_W = 256, NUM_OPS = 1, beats A, B, C, D: op_data = {A, B, C, D}. Result R is emitted as R[255:192] first.
- Back-to-back transactions: the second load begins the cycle after the last unload word and gives correct independent results; op_data is unchanged until the second load's first accepted beat.
